// File: rtl/miriscv_prog_loader.sv
// Boot-time program loader: takes a length-prefixed little-endian word image over a byte stream,
// writes it into RAM from word 0 upward and then releases the core reset. `MIRISCV_LOADER_CSUM_EN adds an XOR checksum byte.
module miriscv_prog_loader #(
    parameter int unsigned RAM_SIZE = 512
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_rst_n_o,
    output logic        done_o,
    output logic        error_o
);

    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_DATA  = 3'd1,
        ST_CSUM  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

`ifdef MIRISCV_LOADER_CSUM_EN
    localparam state_e ST_FINAL = ST_CSUM;
`else
    localparam state_e ST_FINAL = ST_DONE;
`endif

    state_e      state_q, state_d;
    logic        ready_q;
    logic        done_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] shift_q;
    logic [29:0] widx_q;
    logic [29:0] last_idx_q;
    logic [31:0] word_full;
    logic        accept;
    logic        last_byte;
`ifdef MIRISCV_LOADER_CSUM_EN
    logic [7:0]  csum_q;
`endif

    // The three bytes already held plus the byte on the bus form the complete little-endian word.
    assign word_full    = {byte_i, shift_q};
    assign accept       = byte_valid_i & ready_q;
    assign last_byte    = accept && (byte_cnt_q == 2'd3);

    assign byte_ready_o = ready_q;
    assign done_o       = done_q;
    assign core_rst_n_o = done_q;
    assign error_o      = (state_q == ST_ERROR);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_LEN: begin
                if (last_byte) begin
                    if (word_full > 32'(RAM_SIZE)) state_d = ST_ERROR;
                    else if (word_full == 32'd0)   state_d = ST_FINAL;
                    else                           state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last_byte && (widx_q == last_idx_q)) state_d = ST_FINAL;
            end
`ifdef MIRISCV_LOADER_CSUM_EN
            ST_CSUM: begin
                if (accept) state_d = (byte_i == csum_q) ? ST_DONE : ST_ERROR;
            end
`endif
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_ERROR;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_LEN;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            byte_cnt_q  <= 2'd0;
            shift_q     <= 24'd0;
            widx_q      <= 30'd0;
            last_idx_q  <= 30'd0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;
`ifdef MIRISCV_LOADER_CSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            // Ready is registered so it tracks the state being entered and stays low during reset.
            ready_q  <= (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
            mem_we_o <= 1'b0;
            if (state_q == ST_DONE) done_q <= 1'b1;

            if (accept && ((state_q == ST_LEN) || (state_q == ST_DATA))) begin
                shift_q    <= word_full[31:8];
                byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef MIRISCV_LOADER_CSUM_EN
                csum_q     <= csum_q ^ byte_i;
`endif
                if (last_byte && (state_q == ST_LEN)) begin
                    // Only meaningful when 1 <= N <= RAM_SIZE, where it fits the index width.
                    last_idx_q <= 30'(word_full - 32'd1);
                end
                if (last_byte && (state_q == ST_DATA)) begin
                    mem_we_o    <= 1'b1;
                    mem_addr_o  <= {widx_q, 2'b00};
                    mem_wdata_o <= word_full;
                    widx_q      <= widx_q + 30'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_miriscv_prog_loader.sv
// Self-checking bench for miriscv_prog_loader: table of images plus hand-written latency/reset/checksum sequences,
// with RAM writes checked against a scoreboard queue.
module tb_miriscv_prog_loader;

    localparam int unsigned RAM_SIZE = 512;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [7:0]  byte_i = 8'd0;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        core_rst_n_o;
    logic        done_o;
    logic        error_o;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string       name;
        logic [31:0] n;
        logic [31:0] seed;
        bit          gap;
        bit          exp_err;
    } vec_t;

    wr_t        exp_q[$];
    int         strobe_cnt = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] csum = 8'd0;

    miriscv_prog_loader #(.RAM_SIZE(RAM_SIZE)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .core_rst_n_o (core_rst_n_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    function automatic logic [31:0] word_val(input logic [31:0] seed, input int i);
        return seed ^ (32'(i) * 32'h9E37_79B9);
    endfunction

    // Scoreboard: every write strobe must match the oldest outstanding expected write.
    always @(negedge clk_i) begin
        if (rst_n_i && mem_we_o) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                check("strobe_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr_o, e.addr);
                check("wr_data", mem_wdata_o, e.data);
            end
        end
    end

    task automatic do_reset();
        byte_valid_i = 1'b0;
        @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1 check("reset_outputs", 32'({byte_ready_o, mem_we_o, core_rst_n_o, done_o, error_o}), 32'd0);
        exp_q.delete();
        strobe_cnt = 0;
        csum = 8'd0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int budget;
        if (gap) @(negedge clk_i);
        @(negedge clk_i);
        byte_i       = b;
        byte_valid_i = 1'b1;
        budget       = 0;
        while (!byte_ready_o && budget < 50) begin
            @(negedge clk_i);
            budget++;
        end
        if (!byte_ready_o) check("ready_timeout", 32'(byte_ready_o), 32'd1);
        @(posedge clk_i);
        csum = csum ^ b;
        #1 byte_valid_i = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] n, input bit gap);
        for (int j = 0; j < 4; j++) send_byte(n[8*j +: 8], gap);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap, input int idx);
        for (int j = 0; j < 4; j++) begin
            if (j == 3) exp_q.push_back('{addr: 32'(idx) * 32'd4, data: w});
            send_byte(w[8*j +: 8], gap);
        end
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        @(negedge clk_i);
        while (!(done_o || error_o) && budget < 20) begin
            @(negedge clk_i);
            budget++;
        end
        check("finish_timeout", 32'(done_o | error_o), 32'd1);
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{"n3_toggle", 32'd3, 32'hCAFE_F00D, 1'b1, 1'b0};
        vecs[1] = '{"len_zero", 32'd0, 32'h0, 1'b0, 1'b0};
        vecs[2] = '{"too_long", 32'(RAM_SIZE + 1), 32'h0, 1'b0, 1'b1};
        vecs[3] = '{"n2", 32'd2, 32'h1234_5678, 1'b0, 1'b0};
        vecs[4] = '{"full_ram", 32'(RAM_SIZE), 32'h0BAD_C0DE, 1'b0, 1'b0};

        // First image: exact strobe latency and core release timing.
        do_reset();
        send_len(32'd1, 1'b0);
        send_word(32'h0430_0113, 1'b0, 0);
        @(negedge clk_i);
        check("first_we", 32'(mem_we_o), 32'd1);
        check("first_done_lag", 32'(done_o), 32'd0);
`ifdef MIRISCV_LOADER_CSUM_EN
        send_byte(csum, 1'b0);
        wait_done();
`else
        @(negedge clk_i);
        check("first_we_one_cycle", 32'(mem_we_o), 32'd0);
`endif
        check("first_done", 32'(done_o), 32'd1);
        check("first_core_rst", 32'(core_rst_n_o), 32'd1);
        check("first_strobes", 32'(strobe_cnt), 32'd1);

        for (int v = 0; v < 5; v++) begin
            logic [4:0] fin;
            do_reset();
            send_len(vecs[v].n, vecs[v].gap);
            if (vecs[v].exp_err) begin
                @(negedge clk_i);
                fin = 5'b00001;
            end else begin
                for (int i = 0; i < int'(vecs[v].n); i++)
                    send_word(word_val(vecs[v].seed, i), vecs[v].gap, i);
`ifdef MIRISCV_LOADER_CSUM_EN
                send_byte(csum, vecs[v].gap);
`endif
                wait_done();
                fin = 5'b00110;
            end
            check($sformatf("%s_end_state", vecs[v].name),
                  32'({byte_ready_o, mem_we_o, core_rst_n_o, done_o, error_o}), 32'(fin));
            // Bytes offered after completion must be ignored.
            @(negedge clk_i);
            byte_i       = 8'hA5;
            byte_valid_i = 1'b1;
            repeat (4) @(negedge clk_i);
            byte_valid_i = 1'b0;
            check($sformatf("%s_sticky", vecs[v].name),
                  32'({byte_ready_o, mem_we_o, core_rst_n_o, done_o, error_o}), 32'(fin));
            check($sformatf("%s_strobes", vecs[v].name), 32'(strobe_cnt),
                  vecs[v].exp_err ? 32'd0 : vecs[v].n);
            check($sformatf("%s_sb_empty", vecs[v].name), 32'(exp_q.size()), 32'd0);
        end

        // Reset in the middle of the second word, then reload a one-word image.
        do_reset();
        send_len(32'd2, 1'b0);
        send_word(32'h1111_2222, 1'b0, 0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h33, 1'b0);
        @(negedge clk_i);
        check("midload_strobes", 32'(strobe_cnt), 32'd1);
        check("midload_core_held", 32'(core_rst_n_o), 32'd0);
        do_reset();
        send_len(32'd1, 1'b0);
        send_word(32'hAABB_CCDD, 1'b0, 0);
`ifdef MIRISCV_LOADER_CSUM_EN
        send_byte(csum, 1'b0);
`endif
        wait_done();
        check("reload_done", 32'(done_o), 32'd1);
        check("reload_strobes", 32'(strobe_cnt), 32'd1);

`ifdef MIRISCV_LOADER_CSUM_EN
        do_reset();
        send_len(32'd1, 1'b0);
        send_word(32'h0000_0013, 1'b0, 0);
        send_byte(8'h12, 1'b0);
        wait_done();
        check("csum_good", 32'({core_rst_n_o, done_o, error_o}), 32'b110);

        do_reset();
        send_len(32'd1, 1'b0);
        send_word(32'h0000_0013, 1'b0, 0);
        send_byte(8'h13, 1'b0);
        wait_done();
        @(negedge clk_i);
        check("csum_bad", 32'({core_rst_n_o, done_o, error_o}), 32'b001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
